// File: rtl/player_plot_scheduler.sv
// Player plot scheduler: walks the enabled players round-robin, emits one
// pixel for each player whose position moved, and on request sweeps the
// whole screen with the background colour. All outputs are registered.
module player_plot_scheduler #(
  parameter int NUM_PLAYERS = 4,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int COLOUR_W    = 3,
  parameter int X_MAX       = 159,
  parameter int Y_MAX       = 119,
  parameter int BG_COLOUR   = 0
) (
  input  logic                              CLOCK_50,
  input  logic                              reset,
  input  logic [NUM_PLAYERS*(X_W+Y_W)-1:0]  pos,
  input  logic [NUM_PLAYERS*COLOUR_W-1:0]   colours,
  input  logic [NUM_PLAYERS-1:0]            player_en,
  input  logic                              clear_req,
  input  logic                              plot_ready,
  output logic [X_W-1:0]                    x,
  output logic [Y_W-1:0]                    y,
  output logic [COLOUR_W-1:0]               colour,
  output logic                              plot,
  output logic                              clearing
);

  localparam int P_W   = X_W + Y_W;
  localparam int PTR_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    PLOT  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t                 state_q;
  logic [X_W-1:0]         x_q;
  logic [Y_W-1:0]         y_q;
  logic [COLOUR_W-1:0]    colour_q;
  logic                   plot_q;
  logic                   clearing_q;
  logic                   clear_pend_q;
  logic [PTR_W-1:0]       ptr_q;
  logic [PTR_W-1:0]       sel_q;
  logic [NUM_PLAYERS-1:0] valid_q;
  logic [P_W-1:0]         last_pos_q [NUM_PLAYERS];

  logic [NUM_PLAYERS-1:0] dirty_d;
  logic                   found_d;
  logic [PTR_W-1:0]       pick_d;
  logic [P_W-1:0]         pick_pos_d;
  logic [COLOUR_W-1:0]    pick_col_d;
  logic [PTR_W-1:0]       ptr_next_d;

  // Player index reached by stepping 'off' places past 'base', wrapping.
  function automatic int wrap_idx(input int base, input int off);
    return (base + off) % NUM_PLAYERS;
  endfunction

  // A player needs drawing when enabled and either never drawn or moved.
  always_comb begin
    dirty_d = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      dirty_d[i] = player_en[i] &&
                   (!valid_q[i] || (pos[i*P_W +: P_W] != last_pos_q[i]));
    end
  end

  // Round-robin pick: scanning backwards lets the nearest dirty player
  // after the pointer overwrite any farther one.
  always_comb begin
    found_d    = 1'b0;
    pick_d     = '0;
    pick_pos_d = '0;
    pick_col_d = '0;
    for (int k = NUM_PLAYERS - 1; k >= 0; k--) begin
      if (dirty_d[wrap_idx(int'(ptr_q), k)]) begin
        found_d    = 1'b1;
        pick_d     = PTR_W'(wrap_idx(int'(ptr_q), k));
        pick_pos_d = pos[wrap_idx(int'(ptr_q), k)*P_W +: P_W];
        pick_col_d = colours[wrap_idx(int'(ptr_q), k)*COLOUR_W +: COLOUR_W];
      end
    end
  end

  // Pointer moves to the player after the one just drawn.
  always_comb begin
    ptr_next_d = sel_q + 1'b1;
    if (sel_q == PTR_W'(NUM_PLAYERS - 1)) begin
      ptr_next_d = '0;
    end
  end

  // Scheduler FSM with registered pixel outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= SCAN;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      plot_q       <= 1'b0;
      clearing_q   <= 1'b0;
      clear_pend_q <= 1'b0;
      ptr_q        <= '0;
      sel_q        <= '0;
      valid_q      <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        last_pos_q[i] <= '0;
      end
    end else begin
      case (state_q)
        SCAN: begin
          if (clear_pend_q) begin
            // The pending request is being serviced now, so it is consumed.
            state_q      <= CLEAR;
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= COLOUR_W'(BG_COLOUR);
            plot_q       <= 1'b1;
            clearing_q   <= 1'b1;
            clear_pend_q <= 1'b0;
          end else begin
            if (clear_req) begin
              clear_pend_q <= 1'b1;
            end
            if (found_d) begin
              x_q      <= pick_pos_d[P_W-1 -: X_W];
              y_q      <= pick_pos_d[Y_W-1:0];
              colour_q <= pick_col_d;
              sel_q    <= pick_d;
              plot_q   <= 1'b1;
              state_q  <= PLOT;
            end
          end
        end
        PLOT: begin
          if (clear_req) begin
            clear_pend_q <= 1'b1;
          end
          // Record what was actually drawn, so a move during PLOT stays dirty.
          if (plot_ready) begin
            last_pos_q[sel_q] <= {x_q, y_q};
            valid_q[sel_q]    <= 1'b1;
            ptr_q             <= ptr_next_d;
            plot_q            <= 1'b0;
            state_q           <= SCAN;
          end
        end
        CLEAR: begin
          if (plot_ready) begin
            if (x_q == X_W'(X_MAX)) begin
              if (y_q == Y_W'(Y_MAX)) begin
                valid_q    <= '0;
                x_q        <= '0;
                y_q        <= '0;
                plot_q     <= 1'b0;
                clearing_q <= 1'b0;
                state_q    <= SCAN;
              end else begin
                x_q <= '0;
                y_q <= y_q + 1'b1;
              end
            end else begin
              x_q <= x_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= SCAN;
        end
      endcase
    end
  end

  assign x        = x_q;
  assign y        = y_q;
  assign colour   = colour_q;
  assign plot     = plot_q;
  assign clearing = clearing_q;

endmodule

// File: doc/player_plot_scheduler.md
PLAYER_PLOT_SCHEDULER -- requirements
Module: player_plot_scheduler

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 4, number of player channels (2..16).
REQ-002 SHALL have parameter X_W, default 8, x-coordinate width.
REQ-003 SHALL have parameter Y_W, default 7, y-coordinate width.
REQ-004 SHALL have parameter COLOUR_W, default 3, colour width.
REQ-005 SHALL have parameters X_MAX, default 159, and Y_MAX, default 119, as the last screen column and last screen row.
REQ-006 SHALL have parameter BG_COLOUR, default 0, the colour used for clear sweeps.
REQ-007 SHALL have port CLOCK_50, input, width 1, the sole clock; all logic on its rising edge.
REQ-008 SHALL have port reset, input, width 1, synchronous, active-high reset.
REQ-009 SHALL have port pos, input, width NUM_PLAYERS*(X_W+Y_W), packed player positions: player i occupies slice [i*(X_W+Y_W) +: X_W+Y_W], with x in the upper X_W bits and y in the lower Y_W bits.
REQ-010 SHALL have port colours, input, width NUM_PLAYERS*COLOUR_W, per-player colour; player i occupies slice [i*COLOUR_W +: COLOUR_W].
REQ-011 SHALL have port player_en, input, width NUM_PLAYERS, per-player enable mask.
REQ-012 SHALL have port clear_req, input, width 1, single-cycle request for a full-screen clear.
REQ-013 SHALL have port plot_ready, input, width 1, pixel sink ready.
REQ-014 SHALL have ports x (output, X_W), y (output, Y_W) and colour (output, COLOUR_W), registered pixel data.
REQ-015 SHALL have port plot, output, width 1, pixel valid.
REQ-016 SHALL have port clearing, output, width 1, high while the CLEAR state is active.

Function
REQ-017 SHALL transfer a pixel only on a cycle where plot=1 and plot_ready=1.
REQ-018 SHALL hold x, y and colour stable while plot=1 and no transfer has occurred.
REQ-019 SHALL keep per player i a last_pos register and a valid flag.
REQ-020 SHALL treat player i as dirty when player_en[i]=1 and either valid[i]=0 or pos slice i differs from last_pos[i].
REQ-021 SHALL implement the states SCAN, PLOT and CLEAR.
REQ-022 In SCAN with clear_pend=1, SHALL go to CLEAR, start at pixel (0,0), and clear clear_pend.
REQ-023 In SCAN with clear_pend=0, SHALL select the first dirty player at or after round-robin pointer ptr, wrapping modulo NUM_PLAYERS.
REQ-024 On selecting a player in SCAN, SHALL latch that player's x, y, colour and index, set plot=1 on the next cycle, and go to PLOT.
REQ-025 In SCAN, SHALL stay in SCAN with plot=0 when no player is dirty.
REQ-026 On a transfer in PLOT, SHALL set last_pos[sel] to the latched position, set valid[sel]=1, set ptr to (sel+1) mod NUM_PLAYERS, set plot=0, and return to SCAN.
REQ-027 SHALL compare the latched position at transfer, so a position change during PLOT leaves the player dirty and it is plotted again later.
REQ-028 SHALL complete an in-progress PLOT transfer for a player whose player_en drops during PLOT.
REQ-029 SHALL set clear_pend on clear_req in SCAN or PLOT, and SHALL ignore clear_req in CLEAR.
REQ-030 In CLEAR, SHALL output plot=1 and colour=BG_COLOUR, sweeping pixels in raster order with x fastest (0..X_MAX) and y slowest (0..Y_MAX), advancing one pixel per transfer.
REQ-031 On transfer of pixel (X_MAX,Y_MAX), SHALL clear all valid flags, set x=0 and y=0, set plot=0, deassert clearing, and return to SCAN.
REQ-032 SHALL assert clearing on the cycle CLEAR is entered.
REQ-033 SHALL derive the pointer and sweep counter widths from the parameters, with no truncation at maximum values.

Reset
REQ-034 While reset=1 at a clock edge, SHALL set x=0, y=0, colour=0, plot=0, clearing=0, ptr=0, clear_pend=0, all valid flags=0 and all last_pos=0, and enter SCAN.
REQ-035 Reset SHALL override any in-progress PLOT or CLEAR.
REQ-036 Reset SHALL drop a pending clear.
REQ-037 After reset is released with plot_ready=1, SHALL plot every enabled player once, in index order from 0.

Verification
REQ-038 Reset, all players enabled, plot_ready=1, P0=(10,20) with colour 1, P1=(30,40) with colour 2, P2 and P3 distinct -> four transfers P0, P1, P2, P3, each with plot asserted one cycle after selection; then plot=0 with positions static.
REQ-039 plot_ready=0 for 5 cycles while plot=1 for P1 -> x=30, y=40, colour=2 held stable for all 5 cycles, and the transfer occurs on the first ready cycle.
REQ-040 P2 position changes from (5,5) to (6,5) during P2's PLOT -> (5,5) is transferred, then (6,5) is transferred on a later SCAN.
REQ-041 clear_req pulse during P0's PLOT -> P0's transfer completes, then 160*120=19200 BG pixels are transferred ending at (159,119) with clearing=1 throughout, then all enabled players are replotted.
REQ-042 player_en=4'b0101 with all players dirty and ptr=1 -> order is P2, then P0; P1 and P3 are never plotted.
REQ-043 reset asserted at sweep pixel (50,3) -> next cycle plot=0, clearing=0 and state SCAN; clear_pend=0.
